simmem_addr_arbiter: RTL and testbench

- Shares the single address-insertion port of one delay-calculator rank between the write-address and read-address requester channels.
- Arbitrates with a configurable fixed preference plus a starvation limiter.
- Registers the winner into a one-entry output stage (valid/ready) that drives the delay calculator's address input.
- Sits between the requester-side address snoop and the delay calculator.

---
 rtl/simmem_addr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_simmem_addr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/simmem_addr_arbiter.sv
// Arbitrates the write- and read-address requesters onto one delay-calculator
// address port through a one-entry registered output slot.

module simmem_addr_arbiter #(
  parameter int unsigned WAddrW      = 64,
  parameter int unsigned RAddrW      = 64,
  parameter bit          PreferWrite = 1'b1,
  parameter int unsigned MaxStreak   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [WAddrW-1:0]              waddr_i,
  input  logic                           waddr_valid_i,
  output logic                           waddr_ready_o,
  input  logic [RAddrW-1:0]              raddr_i,
  input  logic                           raddr_valid_i,
  output logic                           raddr_ready_o,
  output logic [WAddrW-1:0]              out_waddr_o,
  output logic [RAddrW-1:0]              out_raddr_o,
  output logic                           out_is_write_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [$clog2(MaxStreak+1)-1:0] streak_o
);

  localparam int unsigned   SW    = $clog2(MaxStreak + 1);
  localparam logic [SW-1:0] MAX_S = SW'(MaxStreak);
  localparam logic [SW-1:0] ONE_S = SW'(32'd1);
  localparam logic          PREF  = PreferWrite ? 1'b1 : 1'b0;

  logic [WAddrW-1:0] out_waddr_r;
  logic [RAddrW-1:0] out_raddr_r;
  logic              out_is_write_r;
  logic              out_valid_r;
  logic [SW-1:0]     streak_r;
  logic              last_side_r;

  logic              slot_free_s;
  logic              contend_s;
  logic              grant_w_s;
  logic              grant_r_s;
  logic              accept_s;
  logic [SW-1:0]     streak_nx_s;
  logic              last_side_nx_s;

  // Pick a single winner; side encoding is 1 = write, 0 = read.
  always_comb begin
    grant_w_s   = 1'b0;
    grant_r_s   = 1'b0;
    contend_s   = waddr_valid_i && raddr_valid_i;
    slot_free_s = !out_valid_r || out_ready_i;
    if (contend_s) begin
      if ((streak_r == MAX_S) && (last_side_r == PREF)) begin
        grant_w_s = !PREF;
        grant_r_s = PREF;
      end else begin
        grant_w_s = PREF;
        grant_r_s = !PREF;
      end
    end else begin
      grant_w_s = waddr_valid_i;
      grant_r_s = raddr_valid_i;
    end
    accept_s = slot_free_s && (grant_w_s || grant_r_s);
  end

  // Starvation limiter: count consecutive contended wins by the same side.
  always_comb begin
    streak_nx_s    = streak_r;
    last_side_nx_s = last_side_r;
    if (accept_s) begin
      last_side_nx_s = grant_w_s;
      if (contend_s) begin
        if (grant_w_s == last_side_r) begin
          streak_nx_s = (streak_r == MAX_S) ? MAX_S : (streak_r + ONE_S);
        end else begin
          streak_nx_s = ONE_S;
        end
      end else begin
        streak_nx_s = '0;
      end
    end else begin
      streak_nx_s    = streak_r;
      last_side_nx_s = last_side_r;
    end
  end

  // Output slot and arbitration history registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_r    <= 1'b0;
      out_is_write_r <= 1'b0;
      out_waddr_r    <= '0;
      out_raddr_r    <= '0;
      streak_r       <= '0;
      last_side_r    <= PREF;
    end else begin
      streak_r    <= streak_nx_s;
      last_side_r <= last_side_nx_s;
      if (accept_s) begin
        out_valid_r    <= 1'b1;
        out_is_write_r <= grant_w_s;
        if (grant_w_s) begin
          out_waddr_r <= waddr_i;
        end else begin
          out_raddr_r <= raddr_i;
        end
      end else if (out_ready_i) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign waddr_ready_o  = slot_free_s && grant_w_s;
  assign raddr_ready_o  = slot_free_s && grant_r_s;
  assign out_waddr_o    = out_waddr_r;
  assign out_raddr_o    = out_raddr_r;
  assign out_is_write_o = out_is_write_r;
  assign out_valid_o    = out_valid_r;
  assign streak_o       = streak_r;

  simmem_addr_arbiter_chk #(
    .WAddrW   (WAddrW),
    .RAddrW   (RAddrW),
    .MaxStreak(MaxStreak)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .waddr_ready_o (waddr_ready_o),
    .raddr_ready_o (raddr_ready_o),
    .out_waddr_o   (out_waddr_r),
    .out_raddr_o   (out_raddr_r),
    .out_is_write_o(out_is_write_r),
    .out_valid_o   (out_valid_r),
    .out_ready_i   (out_ready_i),
    .streak_o      (streak_r)
  );

endmodule

// Simulation-only sanity properties for the arbiter outputs.
module simmem_addr_arbiter_chk #(
  parameter int unsigned WAddrW    = 64,
  parameter int unsigned RAddrW    = 64,
  parameter int unsigned MaxStreak = 4
) (
  input logic                           clk_i,
  input logic                           rst_ni,
  input logic                           waddr_ready_o,
  input logic                           raddr_ready_o,
  input logic [WAddrW-1:0]              out_waddr_o,
  input logic [RAddrW-1:0]              out_raddr_o,
  input logic                           out_is_write_o,
  input logic                           out_valid_o,
  input logic                           out_ready_i,
  input logic [$clog2(MaxStreak+1)-1:0] streak_o
);

  localparam int unsigned SW = $clog2(MaxStreak + 1);

  a_one_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(waddr_ready_o && raddr_ready_o));

  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ($past(rst_ni) && $past(out_valid_o) && !$past(out_ready_i)) |->
      ($stable(out_waddr_o) && $stable(out_raddr_o) && $stable(out_is_write_o) && out_valid_o));

  a_streak_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    streak_o <= SW'(MaxStreak));

endmodule

// File: tb/tb_simmem_addr_arbiter.sv
// Randomized scoreboard bench for simmem_addr_arbiter against a
// behavioural arbitration model.

module tb_simmem_addr_arbiter;

  localparam int unsigned W    = 64;
  localparam int          MS   = 4;
  localparam bit          PREF = 1'b1;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [W-1:0]  waddr_i = '0;
  logic          waddr_valid_i = 1'b0;
  logic          waddr_ready_o;
  logic [W-1:0]  raddr_i = '0;
  logic          raddr_valid_i = 1'b0;
  logic          raddr_ready_o;
  logic [W-1:0]  out_waddr_o;
  logic [W-1:0]  out_raddr_o;
  logic          out_is_write_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [2:0]    streak_o;

  always #5 clk = ~clk;

  simmem_addr_arbiter #(
    .WAddrW(W), .RAddrW(W), .PreferWrite(PREF), .MaxStreak(MS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .waddr_i(waddr_i), .waddr_valid_i(waddr_valid_i), .waddr_ready_o(waddr_ready_o),
    .raddr_i(raddr_i), .raddr_valid_i(raddr_valid_i), .raddr_ready_o(raddr_ready_o),
    .out_waddr_o(out_waddr_o), .out_raddr_o(out_raddr_o),
    .out_is_write_o(out_is_write_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .streak_o(streak_o)
  );

  typedef struct packed {
    logic         is_w;
    logic [W-1:0] pay;
  } item_t;

  item_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: what the slot should hold and the contention history.
  bit           m_valid  = 1'b0;
  bit           m_isw    = 1'b0;
  logic [W-1:0] m_w      = '0;
  logic [W-1:0] m_r      = '0;
  int           m_streak = 0;
  bit           m_last   = PREF;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit wv, input bit rv, input bit ordy,
                      input logic [W-1:0] wp, input logic [W-1:0] rp);
    bit    free, contend, gw, gr, acc;
    item_t it;
    @(posedge clk);
    #1;
    rst_ni        = rst;
    waddr_valid_i = wv;
    raddr_valid_i = rv;
    out_ready_i   = ordy;
    waddr_i       = wp;
    raddr_i       = rp;
    #1;
    free    = !m_valid || ordy;
    contend = wv && rv;
    if (contend) begin
      if (m_streak == MS && m_last == PREF) gw = !PREF;
      else                                  gw = PREF;
      gr = !gw;
    end else begin
      gw = wv;
      gr = rv;
    end
    chk("waddr_ready", W'(waddr_ready_o), W'(free && gw));
    chk("raddr_ready", W'(raddr_ready_o), W'(free && gr));
    chk("out_valid", W'(out_valid_o), W'(m_valid));
    chk("out_is_write", W'(out_is_write_o), W'(m_isw));
    chk("out_waddr", out_waddr_o, m_w);
    chk("out_raddr", out_raddr_o, m_r);
    chk("streak", W'(streak_o), W'(m_streak));
    acc = free && (gw || gr);
    if (!rst) begin
      m_valid = 1'b0; m_isw = 1'b0; m_w = '0; m_r = '0;
      m_streak = 0; m_last = PREF;
      sb.delete();
    end else if (acc) begin
      it.is_w = gw;
      it.pay  = gw ? wp : rp;
      sb.push_back(it);
      if (!contend)         m_streak = 0;
      else if (gw == m_last) m_streak = (m_streak < MS) ? m_streak + 1 : MS;
      else                   m_streak = 1;
      m_last  = gw;
      m_valid = 1'b1;
      m_isw   = gw;
      if (gw) m_w = wp;
      else    m_r = rp;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Monitor: every completed output handshake must match the oldest accepted request.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (rst_ni === 1'b1 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_order: got an output handshake expected none pending");
        end else begin
          it = sb.pop_front();
          chk("sb_is_write", W'(out_is_write_o), W'(it.is_w));
          chk("sb_payload", it.is_w ? out_waddr_o : out_raddr_o, it.pay);
        end
      end
    end
  end

  initial begin
    int wp_pct, rp_pct, op_pct;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // Single write then drain.
    step(1'b1, 1'b1, 1'b0, 1'b1, 64'h12, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);

    // Continuous contention exercises the streak limit.
    repeat (20) step(1'b1, 1'b1, 1'b1, 1'b1, rnd64(), rnd64());

    // Stall with both requesters valid, then release.
    step(1'b1, 1'b1, 1'b1, 1'b1, rnd64(), rnd64());
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, rnd64(), rnd64());
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b1, rnd64(), rnd64());
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);

    // Alternating single-side requests.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, rnd64(), rnd64());
      step(1'b1, 1'b0, 1'b1, 1'b1, rnd64(), rnd64());
    end

    // Back-to-back accept into a draining slot.
    step(1'b1, 1'b1, 1'b0, 1'b1, 64'h12, '0);
    step(1'b1, 1'b0, 1'b1, 1'b1, '0, 64'h34);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);

    // Reset while the slot is full and the streak is 3.
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, rnd64(), rnd64());
    step(1'b0, 1'b1, 1'b1, 1'b0, rnd64(), rnd64());
    step(1'b1, 1'b1, 1'b1, 1'b1, rnd64(), rnd64());

    // Randomized traffic with varying densities and occasional resets.
    for (int blk = 0; blk < 15; blk++) begin
      wp_pct = $urandom_range(90, 10);
      rp_pct = $urandom_range(90, 10);
      op_pct = $urandom_range(95, 20);
      for (int c = 0; c < 200; c++) begin
        step($urandom_range(199) != 0,
             $urandom_range(99) < wp_pct,
             $urandom_range(99) < rp_pct,
             $urandom_range(99) < op_pct,
             rnd64(), rnd64());
      end
    end

    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    @(negedge clk);
    #1;
    chk("sb_drained", W'(sb.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
